// File: rtl/control_datapath.sv
// Single-cycle control/datapath: opcode decode, 4-entry register file and a
// small ALU whose result is written back to R[rx_addr] on the next rising edge.
module control_datapath #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        opcode,
  input  logic [1:0]        rx_addr,
  input  logic [1:0]        ry_addr,
  input  logic [DATA_W-1:0] immediate,
  output logic              reg_write_enable,
  output logic [1:0]        alu_op_select,
  output logic              alu_operand_b_select,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] r0_debug,
  output logic [DATA_W-1:0] r1_debug,
  output logic [DATA_W-1:0] r2_debug,
  output logic [DATA_W-1:0] r3_debug
);

  localparam int unsigned NUM_REGS = 4;

  localparam logic [3:0] OP_LOAD = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_XOR  = 2'b01;
  localparam logic [1:0] ALU_ADD  = 2'b10;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;

  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;

  // Opcode decode; every unlisted opcode is a NOP.
  always_comb begin
    reg_write_enable     = 1'b0;
    alu_op_select        = ALU_PASS;
    alu_operand_b_select = 1'b0;
    case (opcode)
      OP_LOAD: begin
        reg_write_enable     = 1'b1;
        alu_operand_b_select = 1'b1;
      end
      OP_MOV: begin
        reg_write_enable = 1'b1;
      end
      OP_XOR: begin
        reg_write_enable = 1'b1;
        alu_op_select    = ALU_XOR;
      end
      OP_ADD: begin
        reg_write_enable = 1'b1;
        alu_op_select    = ALU_ADD;
      end
      default: ;
    endcase
  end

  // Asynchronous register-file reads and operand B mux.
  always_comb begin
    operand_a = regs_q[rx_addr];
    operand_b = alu_operand_b_select ? immediate : regs_q[ry_addr];
  end

  // ALU; the add wraps modulo 2^DATA_W, and codes 00/11 both pass B.
  always_comb begin
    alu_result = operand_b;
    case (alu_op_select)
      ALU_XOR: alu_result = operand_a ^ operand_b;
      ALU_ADD: alu_result = DATA_W'(operand_a + operand_b);
      default: alu_result = operand_b;
    endcase
  end

  // Write-back: only the destination register changes.
  always_comb begin
    regs_d = regs_q;
    if (reg_write_enable) begin
      regs_d[rx_addr] = alu_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign r0_debug = regs_q[0];
  assign r1_debug = regs_q[1];
  assign r2_debug = regs_q[2];
  assign r3_debug = regs_q[3];

endmodule

// File: tb/tb_control_datapath.sv
// Directed, table-driven bench for control_datapath: decode sweep, program
// execution, wrap-around, self-operand, NOP and asynchronous reset sequences.
module tb_control_datapath;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NUM_VECS = 15;

  logic              clk;
  logic              rst_n;
  logic [3:0]        opcode;
  logic [1:0]        rx_addr;
  logic [1:0]        ry_addr;
  logic [DATA_W-1:0] immediate;
  logic              reg_write_enable;
  logic [1:0]        alu_op_select;
  logic              alu_operand_b_select;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] r0_debug;
  logic [DATA_W-1:0] r1_debug;
  logic [DATA_W-1:0] r2_debug;
  logic [DATA_W-1:0] r3_debug;

  int total;
  int bad;

  control_datapath #(.DATA_W(DATA_W)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .opcode               (opcode),
    .rx_addr              (rx_addr),
    .ry_addr              (ry_addr),
    .immediate            (immediate),
    .reg_write_enable     (reg_write_enable),
    .alu_op_select        (alu_op_select),
    .alu_operand_b_select (alu_operand_b_select),
    .alu_result           (alu_result),
    .r0_debug             (r0_debug),
    .r1_debug             (r1_debug),
    .r2_debug             (r2_debug),
    .r3_debug             (r3_debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]        op;
    logic [1:0]        rx;
    logic [1:0]        ry;
    logic [DATA_W-1:0] imm;
    logic              we;
    logic [1:0]        aop;
    logic              bsel;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] r0;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
    logic [DATA_W-1:0] r3;
  } vec_t;

  vec_t vecs [NUM_VECS];

  function automatic vec_t mk(input logic [3:0] op, input logic [1:0] rx, input logic [1:0] ry,
                              input logic [7:0] imm, input logic we, input logic [1:0] aop,
                              input logic bsel, input logic [7:0] alu, input logic [7:0] r0,
                              input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] r3);
    vec_t v;
    v.op = op; v.rx = rx; v.ry = ry; v.imm = imm;
    v.we = we; v.aop = aop; v.bsel = bsel; v.alu = alu;
    v.r0 = r0; v.r1 = r1; v.r2 = r2; v.r3 = r3;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string name, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    check({name, ".r0"}, 32'(r0_debug), 32'(e0));
    check({name, ".r1"}, 32'(r1_debug), 32'(e1));
    check({name, ".r2"}, 32'(r2_debug), 32'(e2));
    check({name, ".r3"}, 32'(r3_debug), 32'(e3));
  endtask

  task automatic drive(input logic [3:0] op, input logic [1:0] rx, input logic [1:0] ry,
                       input logic [7:0] imm);
    opcode = op; rx_addr = rx; ry_addr = ry; immediate = imm;
  endtask

  initial begin
    logic       exp_we;
    logic [1:0] exp_aop;
    logic       exp_bsel;

    total = 0;
    bad   = 0;

    //        op    rx    ry    imm    we    aop    bs    alu    r0     r1     r2     r3
    vecs[0]  = mk(4'h0, 2'd0, 2'd0, 8'h05, 1'b1, 2'b00, 1'b1, 8'h05, 8'h05, 8'h00, 8'h00, 8'h00);
    vecs[1]  = mk(4'h0, 2'd1, 2'd0, 8'h0A, 1'b1, 2'b00, 1'b1, 8'h0A, 8'h05, 8'h0A, 8'h00, 8'h00);
    vecs[2]  = mk(4'h3, 2'd0, 2'd1, 8'h00, 1'b1, 2'b10, 1'b0, 8'h0F, 8'h0F, 8'h0A, 8'h00, 8'h00);
    vecs[3]  = mk(4'h1, 2'd2, 2'd0, 8'h00, 1'b1, 2'b00, 1'b0, 8'h0F, 8'h0F, 8'h0A, 8'h0F, 8'h00);
    vecs[4]  = mk(4'h0, 2'd3, 2'd0, 8'hAA, 1'b1, 2'b00, 1'b1, 8'hAA, 8'h0F, 8'h0A, 8'h0F, 8'hAA);
    vecs[5]  = mk(4'h2, 2'd2, 2'd3, 8'h00, 1'b1, 2'b01, 1'b0, 8'hA5, 8'h0F, 8'h0A, 8'hA5, 8'hAA);
    vecs[6]  = mk(4'h0, 2'd0, 2'd0, 8'hF0, 1'b1, 2'b00, 1'b1, 8'hF0, 8'hF0, 8'h0A, 8'hA5, 8'hAA);
    vecs[7]  = mk(4'h0, 2'd1, 2'd0, 8'h20, 1'b1, 2'b00, 1'b1, 8'h20, 8'hF0, 8'h20, 8'hA5, 8'hAA);
    vecs[8]  = mk(4'h3, 2'd0, 2'd1, 8'h00, 1'b1, 2'b10, 1'b0, 8'h10, 8'h10, 8'h20, 8'hA5, 8'hAA);
    vecs[9]  = mk(4'h0, 2'd1, 2'd0, 8'h33, 1'b1, 2'b00, 1'b1, 8'h33, 8'h10, 8'h33, 8'hA5, 8'hAA);
    vecs[10] = mk(4'h3, 2'd1, 2'd1, 8'h00, 1'b1, 2'b10, 1'b0, 8'h66, 8'h10, 8'h66, 8'hA5, 8'hAA);
    vecs[11] = mk(4'h2, 2'd1, 2'd1, 8'h00, 1'b1, 2'b01, 1'b0, 8'h00, 8'h10, 8'h00, 8'hA5, 8'hAA);
    // NOPs: alu still passes R[ry_addr], nothing is written
    vecs[12] = mk(4'hF, 2'd1, 2'd2, 8'hFF, 1'b0, 2'b00, 1'b0, 8'hA5, 8'h10, 8'h00, 8'hA5, 8'hAA);
    vecs[13] = mk(4'hF, 2'd3, 2'd0, 8'h12, 1'b0, 2'b00, 1'b0, 8'h10, 8'h10, 8'h00, 8'hA5, 8'hAA);
    vecs[14] = mk(4'hF, 2'd0, 2'd3, 8'h77, 1'b0, 2'b00, 1'b0, 8'hAA, 8'h10, 8'h00, 8'hA5, 8'hAA);

    rst_n = 1'b0;
    drive(4'hF, 2'd0, 2'd0, 8'h00);
    #1;

    // Decode sweep while held in reset: outputs stay combinational.
    for (int op = 0; op < 16; op++) begin
      drive(4'(op), 2'd1, 2'd2, 8'h3C);
      #1;
      exp_we = 1'b0; exp_aop = 2'b00; exp_bsel = 1'b0;
      case (op)
        0: begin exp_we = 1'b1; exp_bsel = 1'b1; end
        1: exp_we = 1'b1;
        2: begin exp_we = 1'b1; exp_aop = 2'b01; end
        3: begin exp_we = 1'b1; exp_aop = 2'b10; end
        default: ;
      endcase
      check($sformatf("sweep%0d.we", op), 32'(reg_write_enable), 32'(exp_we));
      check($sformatf("sweep%0d.aop", op), 32'(alu_op_select), 32'(exp_aop));
      check($sformatf("sweep%0d.bsel", op), 32'(alu_operand_b_select), 32'(exp_bsel));
    end
    drive(4'h0, 2'd1, 2'd0, 8'h3C);
    #1;
    check("rst.alu_load_imm", 32'(alu_result), 32'h3C);
    check_regs("rst", 8'h00, 8'h00, 8'h00, 8'h00);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < int'(NUM_VECS); i++) begin
      drive(vecs[i].op, vecs[i].rx, vecs[i].ry, vecs[i].imm);
      #1;
      check($sformatf("v%0d.we", i), 32'(reg_write_enable), 32'(vecs[i].we));
      check($sformatf("v%0d.aop", i), 32'(alu_op_select), 32'(vecs[i].aop));
      check($sformatf("v%0d.bsel", i), 32'(alu_operand_b_select), 32'(vecs[i].bsel));
      check($sformatf("v%0d.alu", i), 32'(alu_result), 32'(vecs[i].alu));
      @(posedge clk);
      #1;
      check_regs($sformatf("v%0d", i), vecs[i].r0, vecs[i].r1, vecs[i].r2, vecs[i].r3);
      @(negedge clk);
    end

    // Async reset pulse mid-cycle with a LOAD in flight.
    drive(4'h0, 2'd1, 2'd0, 8'h55);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_regs("async", 8'h00, 8'h00, 8'h00, 8'h00);
    check("async.alu", 32'(alu_result), 32'h55);
    @(posedge clk);
    #1;
    check_regs("hold", 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'h0, 2'd2, 2'd0, 8'h07);
    @(posedge clk);
    #1;
    check_regs("resume", 8'h00, 8'h00, 8'h07, 8'h00);

    // Full-scale wrap: 0xFF + 0x01 -> 0x00.
    @(negedge clk);
    drive(4'h0, 2'd3, 2'd0, 8'hFF);
    @(negedge clk);
    drive(4'h0, 2'd0, 2'd0, 8'h01);
    @(negedge clk);
    drive(4'h3, 2'd3, 2'd0, 8'h00);
    #1;
    check("wrap.alu", 32'(alu_result), 32'h00);
    @(posedge clk);
    #1;
    check_regs("wrap", 8'h01, 8'h00, 8'h07, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
